// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer: holds core and peripheral resets low after power-up,
// then releases core first and peripheral STAGGER cycles later.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int FILTER      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       power,
    input  logic       sw_reset_req,
    output logic       reset_n_core,
    output logic       reset_n_periph,
    output logic       ready,
    output logic [1:0] seq_state
);

    localparam int MAXC = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int FW   = $clog2(FILTER + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
    localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        HOLD     = 2'd1,
        REL_CORE = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [FW-1:0] filt, filt_nx;
    logic          accept;
    logic          core_nx, periph_nx, ready_nx;

    // accept fires on the sample that completes FILTER consecutive highs, and keeps
    // firing while the request stays high because filt saturates
    always_comb begin
        filt_nx = '0;
        accept  = 1'b0;
        if (sw_reset_req) begin
            accept  = ({1'b0, filt} + (FW + 1)'(1)) >= (FW + 1)'(FILTER);
            filt_nx = (filt == FILT_MAX) ? filt : filt + FW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        if (!power) begin
            state_nx = OFF;
        end else begin
            case (state)
                OFF: state_nx = HOLD;
                HOLD: begin
                    if (accept)                state_nx = HOLD;
                    else if (cnt == HOLD_LAST) state_nx = REL_CORE;
                    else                       cnt_nx   = cnt + CW'(1);
                end
                REL_CORE: begin
                    if (accept)                state_nx = HOLD;
                    else if (cnt == STAG_LAST) state_nx = RUN;
                    else                       cnt_nx   = cnt + CW'(1);
                end
                RUN: if (accept) state_nx = HOLD;
                default: state_nx = OFF;
            endcase
        end
        // outputs are decoded from the next state so they register on the same edge
        core_nx   = (state_nx == REL_CORE) || (state_nx == RUN);
        periph_nx = (state_nx == RUN);
        ready_nx  = (state_nx == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= OFF;
            cnt            <= '0;
            filt           <= '0;
            reset_n_core   <= 1'b0;
            reset_n_periph <= 1'b0;
            ready          <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            filt           <= filt_nx;
            reset_n_core   <= core_nx;
            reset_n_periph <= periph_nx;
            ready          <= ready_nx;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and random stimulus for reset_sequencer, checked every cycle against a
// timestamp-based model of the release schedule.
module tb_reset_sequencer;

    localparam int H = 16;
    localparam int S = 4;
    localparam int F = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       power = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       reset_n_core;
    logic       reset_n_periph;
    logic       ready;
    logic [1:0] seq_state;

    reset_sequencer #(
        .HOLD_CYCLES(H),
        .STAGGER    (S),
        .FILTER     (F)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .power         (power),
        .sw_reset_req  (sw_reset_req),
        .reset_n_core  (reset_n_core),
        .reset_n_periph(reset_n_periph),
        .ready         (ready),
        .seq_state     (seq_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: the sequence is "on" since edge t0; the phase follows from elapsed edges.
    int cyc     = 0;
    bit m_on    = 1'b0;
    int t0      = 0;
    int run_len = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_state();
        int e;
        if (!m_on) return 0;
        e = cyc - t0;
        if (e < H) return 1;
        if (e < H + S) return 2;
        return 3;
    endfunction

    task automatic step(input logic r, input logic p, input logic s);
        bit acc;
        int es;
        reset = r;
        power = p;
        sw_reset_req = s;
        @(posedge clock);
        cyc++;
        if (r) begin
            m_on    = 1'b0;
            run_len = 0;
        end else begin
            run_len = s ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
            acc = s && (run_len >= F);
            if (!p) m_on = 1'b0;
            else if (!m_on || acc) begin
                m_on = 1'b1;
                t0   = cyc;
            end
        end
        #1;
        es = exp_state();
        chk("seq_state", int'(seq_state), es);
        chk("reset_n_core", int'(reset_n_core), (es >= 2) ? 1 : 0);
        chk("reset_n_periph", int'(reset_n_periph), (es == 3) ? 1 : 0);
        chk("ready", int'(ready), (es == 3) ? 1 : 0);
        chk("periph_le_core", int'(reset_n_periph & ~reset_n_core), 0);
    endtask

    task automatic run_until(input logic [1:0] tgt, input int budget, output int n);
        n = 0;
        do begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end while (seq_state !== tgt && n < budget);
    endtask

    initial begin
        int  n;
        bit  rsw;
        bit  rp;
        bit  rr;

        // cold start
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run_until(2'd2, 60, n);
        chk("cold_hold_len", n, H);
        run_until(2'd3, 60, n);
        chk("cold_stagger_len", n, S);

        // short soft-reset pulse is ignored
        repeat (F - 1) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // accepted soft reset, then full re-run
        repeat (F) step(1'b0, 1'b1, 1'b1);
        chk("accept_to_hold", int'(seq_state), 1);
        run_until(2'd3, 60, n);
        chk("rerun_len", n, H + S);

        // held request keeps HOLD; release gives a full HOLD
        repeat (40) step(1'b0, 1'b1, 1'b1);
        run_until(2'd2, 60, n);
        chk("held_release_len", n, H);
        run_until(2'd3, 60, n);

        // power loss in REL_CORE coincident with an accepted request
        repeat (F) step(1'b0, 1'b1, 1'b1);
        run_until(2'd2, 60, n);
        repeat (F - 1) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("powerloss_off", int'(seq_state), 0);
        step(1'b0, 1'b1, 1'b0);
        run_until(2'd3, 60, n);
        chk("powerloss_rerun_len", n, H + S);

        // power glitch, then master reset at counter=10 in HOLD
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("midhold_reset_off", int'(seq_state), 0);
        step(1'b0, 1'b1, 1'b0);
        run_until(2'd2, 60, n);
        chk("post_reset_hold_len", n, H);
        run_until(2'd3, 60, n);

        // random run with bursty requests and rare power drops / resets
        rsw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rsw = ~rsw;
            rp = ($urandom_range(0, 40) != 0);
            rr = ($urandom_range(0, 80) == 0);
            step(rr, rp, rsw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
